// File: rtl/rx_buf_pkg.sv
// Shared constants and types for the receive-side elastic buffer.
// Covers the link/FIFO defaults, pointer sizing and drop-counter limits.
package rx_buf_pkg;

    localparam int DATA_W_DEF = 5;
    localparam int DEPTH_DEF  = 4;

    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    // One extra MSB so a full FIFO is distinguishable from an empty one.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W_DEF = ptr_width(DEPTH_DEF);

    typedef struct packed {
        logic wr;
        logic rd;
        logic drop;
    } rx_ev_t;

endpackage

// File: rtl/rx_buf_ram.sv
// Register array for the receive buffer: one write port and one
// asynchronous read port. The contents reset to zero.
module rx_buf_ram
    import rx_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/receive_buffer.sv
// Receive elastic buffer: no-backpressure link in, valid/ready out.
// Define RX_BUF_DROP_CNT_EN to add the saturating drop_cnt output.
module receive_buffer
    import rx_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
`ifdef RX_BUF_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0]    drop_cnt,
`endif
    input  logic                     ovf_clr
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int AW    = PTR_W - 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             empty, full;
    rx_ev_t           ev;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[AW] != rd_ptr_q[AW]);
        ev.rd   = !empty && out_ready;
        // A read in the same cycle frees the slot the write lands in.
        ev.wr   = in_valid && (!full || ev.rd);
        ev.drop = in_valid && full && !ev.rd;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(ev.wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(ev.rd);
        level_d  = level_q;
        unique case ({ev.wr, ev.rd})
            2'b10:   level_d = level_q + PTR_W'(1);
            2'b01:   level_d = level_q - PTR_W'(1);
            default: level_d = level_q;
        endcase
        ovf_d = ovf_q;
        if (ev.drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef RX_BUF_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // A clear coinciding with a drop restarts the count at one.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ev.drop) begin
            if (ovf_clr) begin
                drop_cnt_d = DROP_CNT_W'(1);
            end else if (drop_cnt_q != DROP_CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
        end else if (ovf_clr) begin
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    rx_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ev.wr),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (out_data)
    );

    assign out_valid = !empty;
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_receive_buffer.sv
// Scoreboard bench for receive_buffer: directed scenarios plus random
// traffic checked against a queue-based model of the FIFO.
module tb_receive_buffer;

    localparam int DW    = 5;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          overflow;
    logic          ovf_clr;
`ifdef RX_BUF_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] exp_q[$];
    int m_cnt;
    bit m_ovf;
    int m_drops;

    receive_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
`ifdef RX_BUF_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: occupancy count plus ordered queue of accepted words.
    task automatic model(input bit v, input logic [DW-1:0] d,
                         input bit r, input bit c);
        bit rd, wr, drop;
        rd   = (m_cnt > 0) && r;
        wr   = v && ((m_cnt < DEPTH) || rd);
        drop = v && !wr;
        if (wr) exp_q.push_back(d);
        m_cnt = m_cnt + int'(wr) - int'(rd);
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (drop) m_drops = c ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
        else if (c) m_drops = 0;
    endtask

    task automatic check_state();
        chk("level", 32'(level), 32'(m_cnt));
        chk("out_valid", 32'(out_valid), 32'(m_cnt > 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef RX_BUF_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
    endtask

    // Called at posedge+1: drive, take one edge, update model and check.
    task automatic step(input bit v, input logic [DW-1:0] d,
                        input bit r, input bit c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        ovf_clr   = c;
        @(posedge clk);
        #1;
        model(v, d, r, c);
        check_state();
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_read: got %0h expected none at %0t",
                         out_data, $time);
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        #12;
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0);
        chk("idle_out_data", 32'(out_data), 32'd0);

        step(1, 5'h11, 0, 0);
        step(1, 5'h02, 0, 0);
        step(1, 5'h1F, 0, 0);
        repeat (3) step(0, 0, 1, 0);

        for (int i = 0; i < 4; i++) step(1, 5'(5'h08 + i), 0, 0);
        step(1, 5'h05, 0, 0);
        repeat (4) step(0, 0, 1, 0);
        step(0, 0, 0, 1);

        for (int i = 0; i < 4; i++) step(1, 5'(5'h14 + i), 0, 0);
        for (int i = 0; i < 10; i++) step(1, 5'($urandom), 1, 0);
        repeat (4) step(0, 0, 1, 0);

        for (int i = 0; i < 4; i++) step(1, 5'($urandom), 0, 0);
        step(1, 5'h1A, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 300; i++) step(1, 5'($urandom), 0, 0);
        step(0, 0, 0, 1);
        repeat (4) step(0, 0, 1, 0);

        for (int i = 0; i < 3; i++) step(1, 5'(5'h03 + i), 0, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state();
        step(1, 5'h0A, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        for (int i = 0; i < 600; i++) begin
            bit busy;
            busy = ((i / 40) % 2) == 1;
            step($urandom_range(0, 3) != 0, 5'($urandom),
                 busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 15) == 0);
        end

        repeat (DEPTH + 2) step(0, 0, 1, 0);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
